// File: rtl/avalonsemi_tbb1143_if.sv
// Host write bus of the sound generator: 4-bit data nibble, address/data select and write strobe.
// The host drives it through the master modport and the generator receives it through the slave modport.
interface avalonsemi_tbb1143_if;
    logic D0;
    logic D1;
    logic D2;
    logic D3;
    logic A0;
    logic WR;

    modport master (output D0, D1, D2, D3, A0, WR);
    modport slave  (input  D0, D1, D2, D3, A0, WR);
endinterface

// File: rtl/avalonsemi_tbb1143.sv
// Nibble-bus programmable sound generator: two square-wave tone channels and one LFSR noise
// channel, mixed into a registered 6-bit sample for an external R-2R DAC.
module avalonsemi_tbb1143 (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       FCLK,
    avalonsemi_tbb1143_if.slave        bus,
    output logic                       S0,
    output logic                       S1,
    output logic                       S2,
    output logic                       S3,
    output logic                       S4,
    output logic                       S5,
    output logic                       LED0,
    output logic                       LED1
);

    typedef struct packed {
        logic [11:0] cnt;
        logic        tone;
    } tone_t;

    localparam logic [14:0] LFSR_SEED = 15'h0001;

    // FCLK is a reserved pad with no function inside the block.
    logic unused_fclk;
    assign unused_fclk = FCLK;

    logic        wr_q, wr_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  regs_q [16];
    logic [3:0]  regs_d [16];
    tone_t       ch0_q, ch0_d;
    tone_t       ch1_q, ch1_d;
    logic [7:0]  cntn_q, cntn_d;
    logic [14:0] lfsr_q, lfsr_d;
    logic [5:0]  sample_q, sample_d;

    logic [3:0]  bus_data;
    logic        wr_edge;
    logic [11:0] p0, p1;
    logic [7:0]  pn;
    logic [3:0]  v0, v1, vn;
    logic        en0, en1, enn;
    logic        noise_on;

    assign bus_data = {bus.D3, bus.D2, bus.D1, bus.D0};
    assign wr_edge  = bus.WR & ~wr_q;

    assign p0  = {regs_q[2], regs_q[1], regs_q[0]};
    assign v0  = regs_q[3];
    assign p1  = {regs_q[6], regs_q[5], regs_q[4]};
    assign v1  = regs_q[7];
    assign pn  = {regs_q[9], regs_q[8]};
    assign vn  = regs_q[10];
    assign en0 = regs_q[11][0];
    assign en1 = regs_q[11][1];
    assign enn = regs_q[11][2];

    assign noise_on = enn && (pn != 8'd0);

    // One tone-channel step; a running channel keeps its count across period changes.
    function automatic tone_t tone_step(input tone_t cur, input logic en, input logic [11:0] p);
        tone_t nxt;
        nxt = '0;
        if (en && (p != 12'd0)) begin
            if (cur.cnt >= p) begin
                nxt.cnt  = 12'd0;
                nxt.tone = ~cur.tone;
            end else begin
                nxt.cnt  = cur.cnt + 12'd1;
                nxt.tone = cur.tone;
            end
        end
        return nxt;
    endfunction

    // Host bus: one write per rising edge of WR, no matter how long WR stays high.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves a latch.
        wr_d   = bus.WR;
        ptr_d  = ptr_q;
        regs_d = regs_q;
        if (wr_edge) begin
            if (bus.A0) begin
                regs_d[ptr_q] = bus_data;
                ptr_d         = ptr_q + 4'd1;
            end else begin
                ptr_d = bus_data;
            end
        end
    end

    // Channel datapath reads only regs_q, so a write lands one cycle after its edge.
    always_comb begin
        ch0_d  = tone_step(ch0_q, en0, p0);
        ch1_d  = tone_step(ch1_q, en1, p1);
        cntn_d = 8'd0;
        lfsr_d = lfsr_q;
        if (noise_on) begin
            if (cntn_q >= pn) begin
                lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
            end else begin
                cntn_d = cntn_q + 8'd1;
            end
        end
    end

    // Mixer works from the current tone/noise flops, so the sample trails the LEDs by a cycle.
    always_comb begin
        sample_d = 6'd0;
        if (ch0_q.tone) begin
            sample_d = sample_d + {2'b00, v0};
        end
        if (ch1_q.tone) begin
            sample_d = sample_d + {2'b00, v1};
        end
        if (noise_on && lfsr_q[0]) begin
            sample_d = sample_d + {2'b00, vn};
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state flops use non-blocking assignment so every flop sees pre-edge values.
        if (RST) begin
            wr_q     <= 1'b0;
            ptr_q    <= 4'd0;
            // NOTE: the register file is reset too; a cleared file is what guarantees silence.
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 4'd0;
            end
            ch0_q    <= '0;
            ch1_q    <= '0;
            cntn_q   <= 8'd0;
            lfsr_q   <= LFSR_SEED;
            sample_q <= 6'd0;
        end else begin
            wr_q     <= wr_d;
            ptr_q    <= ptr_d;
            regs_q   <= regs_d;
            ch0_q    <= ch0_d;
            ch1_q    <= ch1_d;
            cntn_q   <= cntn_d;
            lfsr_q   <= lfsr_d;
            sample_q <= sample_d;
        end
    end

    assign {S5, S4, S3, S2, S1, S0} = sample_q;
    assign LED0 = ch0_q.tone;
    assign LED1 = ch1_q.tone;

endmodule

// File: tb/tb_avalonsemi_tbb1143.sv
// Directed self-checking bench for the nibble-bus sound generator.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_avalonsemi_tbb1143;

    logic CLK;
    logic RST;
    logic FCLK;
    logic S0, S1, S2, S3, S4, S5;
    logic LED0, LED1;
    logic [5:0] s_val;

    int checks;
    int errors;
    int cyc;
    int last_wr;

    avalonsemi_tbb1143_if bus ();

    avalonsemi_tbb1143 dut (
        .CLK  (CLK),
        .RST  (RST),
        .FCLK (FCLK),
        .bus  (bus.slave),
        .S0   (S0),
        .S1   (S1),
        .S2   (S2),
        .S3   (S3),
        .S4   (S4),
        .S5   (S5),
        .LED0 (LED0),
        .LED1 (LED1)
    );

    assign s_val = {S5, S4, S3, S2, S1, S0};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Edge index: after the k-th rising edge (plus 1 ns) cyc reads k.
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic a0, input logic [3:0] d);
        bus.A0 = a0;
        {bus.D3, bus.D2, bus.D1, bus.D0} = d;
    endtask

    // One bus write: WR high for one edge, then low for one edge. last_wr = edge of the write.
    task automatic bus_wr(input logic a0, input logic [3:0] d);
        drive(a0, d);
        bus.WR = 1'b1;
        tick();
        last_wr = cyc;
        bus.WR = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        bus.WR = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Tone state n edges after the enabling write, for a channel with half-period 'half'.
    function automatic int tone_exp(input int n, input int half);
        if (n < 0) return 0;
        return (n / half) % 2;
    endfunction

    // LFSR bit0 m edges after enabling noise with PN=1 (a shift every 2 edges, seed 0001).
    function automatic int noise_bit_exp(input int m);
        if (m < 2)  return 1;
        if (m < 28) return 0;
        if (m < 32) return 1;
        return 0;
    endfunction

    task automatic test_reset();
        apply_reset();
        bus_wr(0, 4'h0);
        bus_wr(1, 4'h3); bus_wr(1, 4'h0); bus_wr(1, 4'h0); bus_wr(1, 4'hF);
        bus_wr(0, 4'hB);
        bus_wr(1, 4'h1);
        repeat (6) tick();
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 2) drive(0, 4'hB); else drive(1, 4'h7);
            bus.WR = (i % 2 == 0);
            tick();
            checks++;
            if ({LED1, LED0, s_val} !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got LED1/LED0/S=%b/%b/%0d want 0/0/0", i, LED1, LED0, s_val);
            end
        end
        bus.WR = 1'b0;
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({LED1, LED0, s_val} !== 8'h00) begin
                errors++;
                $display("FAIL reset_after[%0d]: got LED1/LED0/S=%b/%b/%0d want 0/0/0", i, LED1, LED0, s_val);
            end
        end
    endtask

    task automatic test_ch0();
        int e;
        int n;
        apply_reset();
        bus_wr(0, 4'h0);
        bus_wr(1, 4'h3); bus_wr(1, 4'h0); bus_wr(1, 4'h0); bus_wr(1, 4'hF);
        bus_wr(0, 4'hB);
        bus_wr(1, 4'h1);
        e = last_wr;
        for (int i = 0; i < 17; i++) begin
            n = cyc - e;
            checks++;
            if (LED0 !== 1'(tone_exp(n, 4))) begin
                errors++;
                $display("FAIL ch0_led0 n=%0d: got %b want %0d", n, LED0, tone_exp(n, 4));
            end
            checks++;
            if (s_val !== 6'(15 * tone_exp(n - 1, 4))) begin
                errors++;
                $display("FAIL ch0_sample n=%0d: got %0d want %0d", n, s_val, 15 * tone_exp(n - 1, 4));
            end
            tick();
        end
    endtask

    task automatic test_mix();
        int e;
        int n;
        apply_reset();
        bus_wr(0, 4'h0);
        bus_wr(1, 4'h3); bus_wr(1, 4'h0); bus_wr(1, 4'h0); bus_wr(1, 4'hF);
        bus_wr(1, 4'h3); bus_wr(1, 4'h0); bus_wr(1, 4'h0); bus_wr(1, 4'hF);
        bus_wr(0, 4'hB);
        bus_wr(1, 4'h3);
        e = last_wr;
        for (int i = 0; i < 12; i++) begin
            n = cyc - e;
            checks++;
            if ({LED1, LED0} !== {2{1'(tone_exp(n, 4))}}) begin
                errors++;
                $display("FAIL mix_leds n=%0d: got %b%b want both %0d", n, LED1, LED0, tone_exp(n, 4));
            end
            checks++;
            if (s_val !== 6'(30 * tone_exp(n - 1, 4))) begin
                errors++;
                $display("FAIL mix_30 n=%0d: got %0d want %0d", n, s_val, 30 * tone_exp(n - 1, 4));
            end
            tick();
        end
        bus_wr(0, 4'h7);
        bus_wr(1, 4'h7);
        for (int i = 0; i < 12; i++) begin
            n = cyc - e;
            checks++;
            if (s_val !== 6'(22 * tone_exp(n - 1, 4))) begin
                errors++;
                $display("FAIL mix_22 n=%0d: got %0d want %0d", n, s_val, 22 * tone_exp(n - 1, 4));
            end
            tick();
        end
    endtask

    task automatic test_noise();
        int e;
        int n;
        apply_reset();
        bus_wr(0, 4'h8);
        bus_wr(1, 4'h1); bus_wr(1, 4'h0); bus_wr(1, 4'hF); bus_wr(1, 4'h4);
        e = last_wr;
        for (int i = 0; i < 33; i++) begin
            n = cyc - e;
            checks++;
            if (s_val !== 6'(15 * noise_bit_exp(n - 1)) || {LED1, LED0} !== 2'b00) begin
                errors++;
                $display("FAIL noise n=%0d: got S=%0d LEDs=%b%b want S=%0d LEDs=00",
                         n, s_val, LED1, LED0, 15 * noise_bit_exp(n - 1));
            end
            tick();
        end
    endtask

    // A single write through a long WR pulse: only reg0 gets 5, ptr lands on 1.
    task automatic test_wr_held();
        int e;
        int n;
        apply_reset();
        bus_wr(0, 4'h0);
        drive(1, 4'h5);
        bus.WR = 1'b1;
        repeat (10) tick();
        bus.WR = 1'b0;
        tick();
        bus_wr(1, 4'h0); bus_wr(1, 4'h0); bus_wr(1, 4'hF);
        bus_wr(0, 4'hB);
        bus_wr(1, 4'h1);
        e = last_wr;
        for (int i = 0; i < 16; i++) begin
            n = cyc - e;
            checks++;
            if (LED0 !== 1'(tone_exp(n, 6)) || s_val !== 6'(15 * tone_exp(n - 1, 6))) begin
                errors++;
                $display("FAIL wr_held n=%0d: got LED0=%b S=%0d want LED0=%0d S=%0d",
                         n, LED0, s_val, tone_exp(n, 6), 15 * tone_exp(n - 1, 6));
            end
            tick();
        end
    endtask

    task automatic test_disable();
        int e;
        int w;
        int n;
        int t0_now, t0_prev, t1_now, t1_prev;
        apply_reset();
        bus_wr(0, 4'h0);
        bus_wr(1, 4'h3); bus_wr(1, 4'h0); bus_wr(1, 4'h0); bus_wr(1, 4'hF);
        bus_wr(1, 4'h3); bus_wr(1, 4'h0); bus_wr(1, 4'h0); bus_wr(1, 4'h7);
        bus_wr(0, 4'hB);
        bus_wr(1, 4'h3);
        e = last_wr;
        bus_wr(0, 4'hB);
        bus_wr(1, 4'h2);
        w = last_wr;
        for (int i = 0; i < 10; i++) begin
            n = cyc - e;
            t0_now  = (cyc <= w)     ? tone_exp(n, 4)     : 0;
            t0_prev = (cyc - 1 <= w) ? tone_exp(n - 1, 4) : 0;
            t1_now  = tone_exp(n, 4);
            t1_prev = tone_exp(n - 1, 4);
            checks++;
            if (LED0 !== 1'(t0_now) || LED1 !== 1'(t1_now)) begin
                errors++;
                $display("FAIL disable_leds n=%0d: got %b%b want %0d%0d", n, LED1, LED0, t1_now, t0_now);
            end
            checks++;
            if (s_val !== 6'(15 * t0_prev + 7 * t1_prev)) begin
                errors++;
                $display("FAIL disable_sample n=%0d: got %0d want %0d", n, s_val, 15 * t0_prev + 7 * t1_prev);
            end
            tick();
        end
    endtask

    task automatic test_p_zero();
        int e;
        int w;
        int n;
        int t0_now, t0_prev;
        apply_reset();
        bus_wr(0, 4'h0);
        bus_wr(1, 4'h3); bus_wr(1, 4'h0); bus_wr(1, 4'h0); bus_wr(1, 4'hF);
        bus_wr(0, 4'hB);
        bus_wr(1, 4'h1);
        e = last_wr;
        repeat (3) tick();
        bus_wr(0, 4'h0);
        bus_wr(1, 4'h0);
        w = last_wr;
        for (int i = 0; i < 10; i++) begin
            n = cyc - e;
            t0_now  = (cyc <= w)     ? tone_exp(n, 4)     : 0;
            t0_prev = (cyc - 1 <= w) ? tone_exp(n - 1, 4) : 0;
            checks++;
            if (LED0 !== 1'(t0_now) || s_val !== 6'(15 * t0_prev)) begin
                errors++;
                $display("FAIL p_zero n=%0d: got LED0=%b S=%0d want LED0=%0d S=%0d",
                         n, LED0, s_val, t0_now, 15 * t0_prev);
            end
            tick();
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        last_wr = 0;
        RST     = 1'b1;
        FCLK    = 1'b0;
        bus.WR  = 1'b0;
        drive(0, 4'h0);
        test_reset();
        test_ch0();
        test_mix();
        test_noise();
        test_wr_held();
        test_disable();
        test_p_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
